signal_change_monitor: RTL and testbench
========================================

# signal_change_monitor

Parametrised, synthesisable change logger for SoC debug. It watches a WIDTH-bit status bus (LEDs or GPIO) and records every value change with a cycle timestamp into an internal show-ahead FIFO. It also flags an idle-timeout watchdog. It sits beside the SOC top, either in the bench or on-chip feeding a UART dump path, and replaces ad-hoc print-on-change and fixed simulation timeouts.

## Interface
- WIDTH, 6: width of monitored bus.
- DEPTH, 16: FIFO entries; power of two, ≥2.
- TS_WIDTH, 24: timestamp counter width.
- TIMEOUT_CYCLES, 10800: idle cycles before timeout (200 µs at 54 MHz); 0 disables the watchdog.

- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- enable  in  1  monitoring active.
- clr  in  1  synchronous clear: flush FIFO, zero timestamp, clear flags, re-arm.
- sig_in  in  WIDTH  monitored bus, synchronous to clk.
- rd_en  in  1  pop head entry.
- rd_valid  out  1  FIFO non-empty; rd_data valid.
- rd_data  out  TS_WIDTH+WIDTH  head entry {timestamp, value}.
- level  out  clog2(DEPTH)+1  entries stored.
- overflow  out  1  sticky: at least one change was dropped.
- timeout  out  1  sticky: no change for TIMEOUT_CYCLES.

## Operation
- States: DISABLED (enable=0), ARMED (first sample pending), RUN.
- DISABLED→ARMED when enable=1. ARMED→RUN on the first enabled edge, which logs sig_in unconditionally. Any state→DISABLED when enable=0.
- Re-enabling re-arms, so the first value is logged again.
- RUN: at each edge, if sig_in ≠ last_q, push {ts_q, sig_in} and set last_q ← sig_in.
- ts_q increments every edge while enable=1. It holds while disabled and wraps modulo 2^TS_WIDTH without any flag.
- Push acceptance: accepted if level<DEPTH, or if level==DEPTH and a pop occurs on the same edge. Otherwise the entry is dropped and overflow←1. last_q still updates on a drop.
- Pop: rd_en with rd_valid=1 removes the head. rd_en with rd_valid=0 is ignored.
- Simultaneous push and pop leaves level unchanged. On an empty FIFO, the pushed entry appears the next cycle.
- Watchdog:
  - idle counter clears on any logged or dropped change and increments otherwise while enabled.
  - When it reaches TIMEOUT_CYCLES, timeout←1 and the counter saturates.
  - timeout clears on the next change or on clr.
  - The counter holds while disabled.
- clr has priority over push, pop and enable effects in that cycle. It empties the FIFO, zeroes ts_q and idle, clears overflow and timeout, and returns to ARMED if enable=1 or DISABLED otherwise.

## Timing
- Reset values: rd_valid=0, rd_data=0, level=0, overflow=0, timeout=0, ts_q=0, state DISABLED.
- Push latency: a change sampled at edge k gives rd_valid=1 and the entry at rd_data after edge k if the FIFO was empty. Logged timestamp = ts_q before the edge-k increment.
- rd_data is show-ahead: it is registered FIFO storage addressed by the read pointer, never X. It reads 0 when empty after reset or clr.
- Pop takes effect at the edge. The next entry is presented in the same cycle as the updated level.
- level, overflow and timeout are registered and change only at clock edges (or asynchronously on reset).
- Reset asserted mid-operation clears everything immediately. The first edge after release behaves as in DISABLED.

## Test plan
- Reset, then enable=1 with sig_in=6'h00 held → one entry {0,6'h00}, level=1. No further entries while sig_in is stable.
- Toggle sig_in to 6'h01 at enabled cycle 5 and 6'h03 at cycle 9, then pop three times → rd_data timestamps 0, 5, 9 with values 00, 01, 03; rd_valid=0 afterwards.
- DEPTH=4, change sig_in every cycle for 6 cycles without popping → level=4, overflow=1, first four entries retained. Change with rd_en=1 at level 4 → accepted, level stays 4.
- TIMEOUT_CYCLES=10, hold sig_in 12 cycles → timeout=1 after the 10th idle edge. A change clears it the next edge. TIMEOUT_CYCLES=0 → never asserts.
- TS_WIDTH=4: a change at enabled cycle 18 → logged timestamp 2 (wrap).
- clr while overflow=1, level=3 → level=0, overflow=0, ts_q=0, next sample logged as first. Assert rst_n=0 mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/signal_change_monitor_if.sv
// Read-side bundle of signal_change_monitor.
//   rd_en     pop request from the consumer
//   rd_valid  FIFO holds at least one entry; rd_data is meaningful
//   rd_data   head entry {timestamp, value}, show-ahead
//   level     number of stored entries
//   overflow  sticky: a change was dropped because the FIFO was full
//   timeout   sticky: no change seen for the idle limit
// modport master is the monitor side; modport slave is the consumer side.
interface signal_change_monitor_if #(
    parameter int unsigned WIDTH    = 6,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned TS_WIDTH = 24
);
    logic                      rd_en;
    logic                      rd_valid;
    logic [TS_WIDTH+WIDTH-1:0] rd_data;
    logic [$clog2(DEPTH):0]    level;
    logic                      overflow;
    logic                      timeout;

    modport master (
        input  rd_en,
        output rd_valid, rd_data, level, overflow, timeout
    );

    modport slave (
        output rd_en,
        input  rd_valid, rd_data, level, overflow, timeout
    );
endinterface

// File: rtl/signal_change_monitor.sv
// signal_change_monitor: logs every value change of a WIDTH-bit status bus,
// tagged with a free-running cycle timestamp, into a show-ahead FIFO, and
// raises a sticky idle-timeout flag when the bus stays quiet too long.
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   enable  monitoring active; dropping it re-arms the first-sample log
//   clr     synchronous flush of FIFO, timestamp, idle counter and flags
//   sig_in  monitored bus, synchronous to clk
//   rd      read-side interface (master modport): rd_en, rd_valid, rd_data,
//           level, overflow, timeout
module signal_change_monitor #(
    parameter int unsigned WIDTH          = 6,
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned TS_WIDTH       = 24,
    parameter int unsigned TIMEOUT_CYCLES = 10800
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   clr,
    input  logic [WIDTH-1:0]       sig_in,
    signal_change_monitor_if.master rd
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH) + 1;
    localparam int unsigned DW = TS_WIDTH + WIDTH;
    localparam int unsigned IW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [IW-1:0] TO_VAL   = IW'(TIMEOUT_CYCLES);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef enum logic [1:0] {
        DISABLED,
        ARMED,
        RUN
    } state_t;

    state_t            state_q, state_d;
    logic              log_first;

    logic [DW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [LW-1:0]     level_q;
    logic [TS_WIDTH-1:0] ts_q;
    logic [WIDTH-1:0]  last_q;
    logic [IW-1:0]     idle_q;
    logic              overflow_q, timeout_q;
    logic              change, pop, push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DISABLED;
        end else begin
            state_q <= state_d;
        end
    end

    // DISABLED and ARMED both log the bus unconditionally on the first
    // enabled edge, so that sample carries the timestamp current at that edge.
    always_comb begin
        state_d   = state_q;
        log_first = 1'b0;
        if (clr) begin
            state_d = enable ? ARMED : DISABLED;
        end else if (!enable) begin
            state_d = DISABLED;
        end else begin
            case (state_q)
                DISABLED, ARMED: begin
                    state_d   = RUN;
                    log_first = 1'b1;
                end
                RUN:     state_d = RUN;
                default: state_d = DISABLED;
            endcase
        end
    end

    assign change = log_first
                  | ((state_q == RUN) & enable & ~clr & (sig_in != last_q));
    assign pop    = ~clr & rd.rd_en & (level_q != '0);
    // A full FIFO still accepts when the head leaves on the same edge; the
    // new entry then lands in the slot the head just vacated.
    assign push   = change & ((level_q != FULL_LVL) | pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[AW'(i)] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            ts_q       <= '0;
            last_q     <= '0;
            idle_q     <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else if (clr) begin
            // Storage is zeroed too so rd_data reads 0 on the empty FIFO.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[AW'(i)] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            ts_q       <= '0;
            last_q     <= '0;
            idle_q     <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {ts_q, sig_in};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level_q <= level_q + 1'b1;
            end else if (pop && !push) begin
                level_q <= level_q - 1'b1;
            end
            if (change) begin
                last_q <= sig_in;
                if (!push) begin
                    overflow_q <= 1'b1;
                end
            end
            if (enable) begin
                ts_q <= ts_q + 1'b1;
                if (change) begin
                    idle_q    <= '0;
                    timeout_q <= 1'b0;
                end else if ((TIMEOUT_CYCLES != 0) && (idle_q != TO_VAL)) begin
                    idle_q <= idle_q + 1'b1;
                    if ((idle_q + 1'b1) == TO_VAL) begin
                        timeout_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign rd.rd_valid = (level_q != '0);
    assign rd.rd_data  = mem[rd_ptr];
    assign rd.level    = level_q;
    assign rd.overflow = overflow_q;
    assign rd.timeout  = timeout_q;

endmodule

// File: tb/tb_signal_change_monitor.sv
// Bench for signal_change_monitor. Two instances share all stimulus: dut_a
// has a 10-cycle watchdog, dut_b has the watchdog disabled. A queue-based
// reference model predicts FIFO contents, flags and timestamps.
module tb_signal_change_monitor;
    localparam int unsigned WIDTH          = 6;
    localparam int unsigned DEPTH          = 4;
    localparam int unsigned TS_WIDTH       = 4;
    localparam int unsigned TIMEOUT_CYCLES = 10;
    localparam int unsigned DW             = TS_WIDTH + WIDTH;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             enable = 1'b0;
    logic             clr    = 1'b0;
    logic [WIDTH-1:0] sig_in = '0;

    signal_change_monitor_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TS_WIDTH(TS_WIDTH)) mon_a ();
    signal_change_monitor_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TS_WIDTH(TS_WIDTH)) mon_b ();

    signal_change_monitor #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .TS_WIDTH(TS_WIDTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr), .sig_in(sig_in), .rd(mon_a)
    );

    signal_change_monitor #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .TS_WIDTH(TS_WIDTH), .TIMEOUT_CYCLES(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr), .sig_in(sig_in), .rd(mon_b)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [DW-1:0]    q [$];
    int unsigned      m_ts;
    int unsigned      m_idle;
    logic             m_first;
    logic             m_ovf;
    logic             m_to;
    logic             m_zero;
    logic [WIDTH-1:0] m_last;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ts    = 0;
        m_idle  = 0;
        m_first = 1'b1;
        m_ovf   = 1'b0;
        m_to    = 1'b0;
        m_zero  = 1'b1;
        m_last  = '0;
    endtask

    task automatic model_edge(input logic en, input logic cl,
                              input logic [WIDTH-1:0] s, input logic rd);
        if (cl) begin
            model_reset();
        end else begin
            if (rd && q.size() > 0) void'(q.pop_front());
            if (en) begin
                if (m_first || s != m_last) begin
                    if (q.size() < DEPTH) begin
                        q.push_back({TS_WIDTH'(m_ts), s});
                        m_zero = 1'b0;
                    end else begin
                        m_ovf = 1'b1;
                    end
                    m_last  = s;
                    m_first = 1'b0;
                    m_idle  = 0;
                    m_to    = 1'b0;
                end else if (m_idle < TIMEOUT_CYCLES) begin
                    m_idle++;
                    if (m_idle == TIMEOUT_CYCLES) m_to = 1'b1;
                end
                m_ts = (m_ts + 1) % (1 << TS_WIDTH);
            end else begin
                m_first = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        check("a.rd_valid", 32'(mon_a.rd_valid), 32'(q.size() > 0));
        check("b.rd_valid", 32'(mon_b.rd_valid), 32'(q.size() > 0));
        check("a.level",    32'(mon_a.level),    32'(q.size()));
        check("b.level",    32'(mon_b.level),    32'(q.size()));
        check("a.overflow", 32'(mon_a.overflow), 32'(m_ovf));
        check("b.overflow", 32'(mon_b.overflow), 32'(m_ovf));
        check("a.timeout",  32'(mon_a.timeout),  32'(m_to));
        check("b.timeout",  32'(mon_b.timeout),  32'd0);
        if (q.size() > 0) begin
            check("a.rd_data", 32'(mon_a.rd_data), 32'(q[0]));
            check("b.rd_data", 32'(mon_b.rd_data), 32'(q[0]));
        end else if (m_zero) begin
            check("a.rd_data_zero", 32'(mon_a.rd_data), 32'd0);
            check("b.rd_data_zero", 32'(mon_b.rd_data), 32'd0);
        end
    endtask

    task automatic step(input logic en, input logic cl,
                        input logic [WIDTH-1:0] s, input logic rd);
        enable      = en;
        clr         = cl;
        sig_in      = s;
        mon_a.rd_en = rd;
        mon_b.rd_en = rd;
        @(posedge clk);
        model_edge(en, cl, s, rd);
        #1;
        check_outputs();
    endtask

    // Reset is asserted between edges and must clear outputs immediately.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check("rst.a.rd_data", 32'(mon_a.rd_data), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [DW-1:0]    exp_tbl [3];
        logic [WIDTH-1:0] s;
        logic             en, cl, rd;
        int unsigned      rd_pct;

        mon_a.rd_en = 1'b0;
        mon_b.rd_en = 1'b0;
        exp_tbl[0] = {4'd0, 6'h00};
        exp_tbl[1] = {4'd5, 6'h01};
        exp_tbl[2] = {4'd9, 6'h03};

        do_reset();

        // First sample, stable bus, then changes at enabled cycles 5 and 9
        for (int k = 0; k < 10; k++) begin
            s = (k < 5) ? 6'h00 : ((k < 9) ? 6'h01 : 6'h03);
            step(1'b1, 1'b0, s, 1'b0);
            if (k == 0 || k == 4) check("first_entry_level", 32'(mon_a.level), 32'd1);
        end
        check("three_entries", 32'(mon_a.level), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("pop_order", 32'(mon_a.rd_data), 32'(exp_tbl[i]));
            step(1'b1, 1'b0, 6'h03, 1'b1);
        end
        check("drained_valid", 32'(mon_a.rd_valid), 32'd0);

        // Overflow: six distinct values into a 4-deep FIFO
        step(1'b1, 1'b1, 6'h00, 1'b0);
        for (int i = 1; i <= 6; i++) step(1'b1, 1'b0, WIDTH'(i), 1'b0);
        check("ovf_level", 32'(mon_a.level), 32'd4);
        check("ovf_flag", 32'(mon_a.overflow), 32'd1);
        check("ovf_head", 32'(mon_a.rd_data), 32'({4'd0, 6'h01}));
        step(1'b1, 1'b0, 6'h07, 1'b1);
        check("full_push_pop_level", 32'(mon_a.level), 32'd4);
        step(1'b1, 1'b0, 6'h07, 1'b1);
        check("level3", 32'(mon_a.level), 32'd3);
        step(1'b1, 1'b1, 6'h07, 1'b0);
        check("clr_level", 32'(mon_a.level), 32'd0);
        check("clr_ovf", 32'(mon_a.overflow), 32'd0);
        step(1'b1, 1'b0, 6'h07, 1'b0);
        check("clr_first_log", 32'(mon_a.rd_data), 32'({4'd0, 6'h07}));

        // Watchdog: 10 idle edges after the first sample
        step(1'b1, 1'b1, 6'h02, 1'b0);
        step(1'b1, 1'b0, 6'h02, 1'b0);
        for (int i = 1; i <= 11; i++) begin
            step(1'b1, 1'b0, 6'h02, 1'b0);
            if (i == 9)  check("timeout_not_yet", 32'(mon_a.timeout), 32'd0);
            if (i == 10) check("timeout_set", 32'(mon_a.timeout), 32'd1);
        end
        step(1'b1, 1'b0, 6'h03, 1'b0);
        check("timeout_cleared", 32'(mon_a.timeout), 32'd0);

        // Timestamp wrap: change at enabled cycle 18 with a 4-bit counter
        step(1'b1, 1'b1, 6'h05, 1'b0);
        for (int k = 0; k < 18; k++) step(1'b1, 1'b0, 6'h05, 1'b0);
        step(1'b1, 1'b0, 6'h06, 1'b0);
        step(1'b1, 1'b0, 6'h06, 1'b1);
        check("ts_wrap", 32'(mon_a.rd_data), 32'({4'd2, 6'h06}));

        // Disable and re-enable re-logs the current value
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 6'h06, 1'b0);
        step(1'b1, 1'b0, 6'h06, 1'b0);
        check("rearm_level", 32'(mon_a.level), 32'd2);

        do_reset();

        // Randomized traffic with occasional mid-stream resets
        s = '0;
        for (int n = 0; n < 3000; n++) begin
            rd_pct = ((n / 250) % 2 == 0) ? 20 : 60;
            en = ($urandom_range(0, 9) != 0);
            cl = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 2) == 0) s = WIDTH'($urandom_range(0, 3));
            rd = ($urandom_range(0, 99) < rd_pct);
            step(en, cl, s, rd);
            if (n % 700 == 699) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
